// File: rtl/lib_seq_ctrl.sv
// lib_seq_ctrl: run sequencer (reset hold, warm-up, gated run, bypass, stop) for a counter datapath
// Define SEQ_TIMEOUT_EN to build the no-wrap timeout fault that drives ERR.
module lib_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int RST_CYCLES = 4,
  parameter int WARM_CYCLES = 2,
  parameter int RUN_WRAPS = 3,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             START,
  input  logic             STOP,
  input  logic             BYP_REQ,
  input  logic [WIDTH-1:0] BYP_VAL,
  input  logic [WIDTH-1:0] CNTR_IN,
  output logic             CNTR_RST_B,
  output logic             SELECT_3,
  output logic             EN_G,
  output logic [WIDTH-1:0] BYPASS,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       WRAP_CNT,
  output logic             ERR
);
  typedef enum logic [2:0] {IDLE, RESET, WARM, RUN, BYP, STOPG} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [WIDTH-1:0] prev;
  logic active, wrap, done_run, tmo;
  logic [7:0] wrap_nxt;
  assign active = state == RUN || state == BYP;
  assign wrap = active && &prev && CNTR_IN == '0;
  assign wrap_nxt = WRAP_CNT + {7'd0, wrap && WRAP_CNT != 8'hff};
  assign done_run = RUN_WRAPS != 0 && {24'd0, wrap_nxt} >= RUN_WRAPS;
`ifdef SEQ_TIMEOUT_EN
  logic [31:0] tcnt;
  assign tmo = active && !wrap && tcnt == 32'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
  assign ERR = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state <= IDLE;
      CNTR_RST_B <= 1'b0;
      SELECT_3 <= 1'b1;
      EN_G <= 1'b0;
      BYPASS <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      WRAP_CNT <= 8'd0;
      cnt <= 8'd0;
      prev <= '0;
`ifdef SEQ_TIMEOUT_EN
      tcnt <= 32'd0;
      ERR <= 1'b0;
`endif
    end else begin
      prev <= CNTR_IN;
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          CNTR_RST_B <= !START;
          EN_G <= 1'b0;
          SELECT_3 <= 1'b1;
          BUSY <= START;
          if (START) begin
            state <= RESET;
            WRAP_CNT <= 8'd0;
            cnt <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
            tcnt <= 32'd0;
            ERR <= 1'b0;
`endif
          end
        end
        RESET: begin
          if (STOP) begin
            state <= STOPG;
            CNTR_RST_B <= 1'b1;
          end else if (cnt == 8'(RST_CYCLES - 1)) begin
            state <= WARM;
            CNTR_RST_B <= 1'b1;
            cnt <= 8'd0;
          end else cnt <= cnt + 8'd1;
        end
        WARM: begin
          if (STOP) state <= STOPG;
          else if (cnt == 8'(WARM_CYCLES - 1)) begin
            state <= RUN;
            EN_G <= 1'b1;
          end else cnt <= cnt + 8'd1;
        end
        RUN, BYP: begin
          WRAP_CNT <= wrap_nxt;
`ifdef SEQ_TIMEOUT_EN
          tcnt <= wrap ? 32'd0 : tcnt + 32'd1;
          ERR <= ERR | tmo;
`endif
          // stop and run completion both outrank a bypass request
          if (STOP || done_run || tmo) begin
            state <= STOPG;
            EN_G <= 1'b0;
            SELECT_3 <= 1'b1;
          end else if (BYP_REQ) begin
            state <= BYP;
            SELECT_3 <= 1'b0;
            if (state == RUN) BYPASS <= BYP_VAL;
          end else begin
            state <= RUN;
            SELECT_3 <= 1'b1;
          end
        end
        STOPG: begin
          state <= IDLE;
          DONE <= 1'b1;
          BUSY <= 1'b0;
          CNTR_RST_B <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lib_seq_ctrl.sv
// tb_lib_seq_ctrl: directed self-checking bench for lib_seq_ctrl with default parameters
module tb_lib_seq_ctrl;
  logic CLK, RST_B, START, STOP, BYP_REQ;
  logic [2:0] BYP_VAL, CNTR_IN;
  logic CNTR_RST_B, SELECT_3, EN_G, BUSY, DONE, ERR;
  logic [2:0] BYPASS;
  logic [7:0] WRAP_CNT;
  int total, bad;

  lib_seq_ctrl dut (
    .CLK(CLK), .RST_B(RST_B), .START(START), .STOP(STOP), .BYP_REQ(BYP_REQ),
    .BYP_VAL(BYP_VAL), .CNTR_IN(CNTR_IN), .CNTR_RST_B(CNTR_RST_B), .SELECT_3(SELECT_3),
    .EN_G(EN_G), .BYPASS(BYPASS), .BUSY(BUSY), .DONE(DONE), .WRAP_CNT(WRAP_CNT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(negedge CLK);
  endtask

  // from IDLE: pulse START and land on the first RUN cycle (cycle 7)
  task automatic start_run();
    START = 1'b1;
    cyc();
    START = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    total++;
    if ({CNTR_RST_B, SELECT_3, EN_G, BUSY, DONE, ERR} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=010000", {CNTR_RST_B, SELECT_3, EN_G, BUSY, DONE, ERR});
    end
    total++;
    if ({BYPASS, WRAP_CNT} !== 11'd0) begin
      bad++;
      $display("FAIL reset_data got=%0h/%0h exp=0/0", BYPASS, WRAP_CNT);
    end
    RST_B = 1'b1;
    cyc();
    total++;
    if (CNTR_RST_B !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_cntr_rst got=%b exp=1", CNTR_RST_B);
    end
  endtask

  task automatic test_start();
    logic [2:0] e;
    START = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      START = 1'b0;
      e = c <= 4 ? 3'b001 : c <= 6 ? 3'b101 : 3'b111;
      total++;
      if ({CNTR_RST_B, EN_G, BUSY} !== e) begin
        bad++;
        $display("FAIL start_seq c=%0d got=%b exp=%b", c, {CNTR_RST_B, EN_G, BUSY}, e);
      end
    end
  endtask

  task automatic test_wraps();
    logic [7:0] ew;
    for (int c = 7; c <= 34; c++) begin
      ew = c < 16 ? 8'd0 : c < 24 ? 8'd1 : c < 32 ? 8'd2 : 8'd3;
      total++;
      if (WRAP_CNT !== ew) begin
        bad++;
        $display("FAIL wrap_cnt c=%0d got=%0d exp=%0d", c, WRAP_CNT, ew);
      end
      total++;
      if ({EN_G, BUSY, DONE} !== {c <= 31, c <= 32, c == 33}) begin
        bad++;
        $display("FAIL wrap_ctl c=%0d got=%b exp=%b", c, {EN_G, BUSY, DONE}, {c <= 31, c <= 32, c == 33});
      end
      if (c <= 31) CNTR_IN = 3'((c - 7) % 8);
      cyc();
    end
  endtask

  task automatic test_bypass();
    CNTR_IN = 3'd0;
    start_run();
    BYP_VAL = 3'd5;
    BYP_REQ = 1'b1;
    cyc();
    total++;
    if ({SELECT_3, EN_G, BYPASS} !== {2'b01, 3'd5}) begin
      bad++;
      $display("FAIL byp_enter got=%b/%b/%0d exp=0/1/5", SELECT_3, EN_G, BYPASS);
    end
    BYP_VAL = 3'd2;
    cyc();
    total++;
    if ({SELECT_3, BYPASS} !== {1'b0, 3'd5}) begin
      bad++;
      $display("FAIL byp_hold got=%b/%0d exp=0/5", SELECT_3, BYPASS);
    end
    BYP_REQ = 1'b0;
    cyc();
    total++;
    if ({SELECT_3, EN_G, BYPASS} !== {2'b11, 3'd5}) begin
      bad++;
      $display("FAIL byp_exit got=%b/%b/%0d exp=1/1/5", SELECT_3, EN_G, BYPASS);
    end
    CNTR_IN = 3'd7;
    BYP_REQ = 1'b1;
    cyc();
    total++;
    if ({SELECT_3, BYPASS} !== {1'b0, 3'd2}) begin
      bad++;
      $display("FAIL byp_reenter got=%b/%0d exp=0/2", SELECT_3, BYPASS);
    end
    CNTR_IN = 3'd0;
    cyc();
    total++;
    if ({SELECT_3, WRAP_CNT} !== {1'b0, 8'd1}) begin
      bad++;
      $display("FAIL byp_wrap got=%b/%0d exp=0/1", SELECT_3, WRAP_CNT);
    end
    BYP_REQ = 1'b0;
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    total++;
    if ({EN_G, SELECT_3, BUSY} !== 3'b011) begin
      bad++;
      $display("FAIL byp_stopg got=%b exp=011", {EN_G, SELECT_3, BUSY});
    end
    cyc();
    total++;
    if ({DONE, BUSY} !== 2'b10) begin
      bad++;
      $display("FAIL byp_done got=%b exp=10", {DONE, BUSY});
    end
  endtask

  task automatic test_priority();
    start_run();
    for (int i = 0; i < 2; i++) begin
      CNTR_IN = 3'd7;
      cyc();
      CNTR_IN = 3'd0;
      cyc();
    end
    CNTR_IN = 3'd7;
    cyc();
    total++;
    if (WRAP_CNT !== 8'd2) begin
      bad++;
      $display("FAIL prio_setup got=%0d exp=2", WRAP_CNT);
    end
    CNTR_IN = 3'd0;
    STOP = 1'b1;
    BYP_REQ = 1'b1;
    cyc();
    STOP = 1'b0;
    BYP_REQ = 1'b0;
    total++;
    if ({EN_G, SELECT_3, BUSY, BYPASS} !== {3'b011, 3'd2}) begin
      bad++;
      $display("FAIL prio_stopg got=%b/%0d exp=011/2", {EN_G, SELECT_3, BUSY}, BYPASS);
    end
    cyc();
    total++;
    if ({DONE, BUSY, SELECT_3} !== 3'b101) begin
      bad++;
      $display("FAIL prio_done got=%b exp=101", {DONE, BUSY, SELECT_3});
    end
    cyc();
    total++;
    if (DONE !== 1'b0) begin
      bad++;
      $display("FAIL prio_done_pulse got=%b exp=0", DONE);
    end
    start_run();
    START = 1'b1;
    cyc();
    START = 1'b0;
    total++;
    if ({CNTR_RST_B, EN_G, BUSY} !== 3'b111) begin
      bad++;
      $display("FAIL start_in_run got=%b exp=111", {CNTR_RST_B, EN_G, BUSY});
    end
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    cyc();
    START = 1'b1;
    STOP = 1'b1;
    cyc();
    START = 1'b0;
    total++;
    if ({CNTR_RST_B, BUSY} !== 2'b01) begin
      bad++;
      $display("FAIL start_stop_idle got=%b exp=01", {CNTR_RST_B, BUSY});
    end
    cyc();
    STOP = 1'b0;
    total++;
    if ({CNTR_RST_B, EN_G, BUSY} !== 3'b101) begin
      bad++;
      $display("FAIL stop_in_reset got=%b exp=101", {CNTR_RST_B, EN_G, BUSY});
    end
    cyc();
    total++;
    if ({DONE, BUSY} !== 2'b10) begin
      bad++;
      $display("FAIL stop_reset_done got=%b exp=10", {DONE, BUSY});
    end
  endtask

  task automatic test_timeout();
    CNTR_IN = 3'd3;
    start_run();
    for (int c = 7; c <= 72; c++) begin
`ifdef SEQ_TIMEOUT_EN
      total++;
      if ({EN_G, ERR, DONE} !== {c <= 70, c >= 71, c == 72}) begin
        bad++;
        $display("FAIL timeout c=%0d got=%b exp=%b", c, {EN_G, ERR, DONE}, {c <= 70, c >= 71, c == 72});
      end
`else
      total++;
      if ({EN_G, ERR, BUSY} !== 3'b101) begin
        bad++;
        $display("FAIL no_timeout c=%0d got=%b exp=101", c, {EN_G, ERR, BUSY});
      end
`endif
      cyc();
    end
`ifdef SEQ_TIMEOUT_EN
    START = 1'b1;
    cyc();
    START = 1'b0;
    total++;
    if (ERR !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_on_start got=%b exp=0", ERR);
    end
`endif
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_midrun();
    CNTR_IN = 3'd0;
    start_run();
    CNTR_IN = 3'd7;
    cyc();
    CNTR_IN = 3'd0;
    BYP_VAL = 3'd6;
    BYP_REQ = 1'b1;
    cyc();
    cyc();
    total++;
    if ({SELECT_3, BYPASS, WRAP_CNT} !== {1'b0, 3'd6, 8'd1}) begin
      bad++;
      $display("FAIL midrun_setup got=%b/%0d/%0d exp=0/6/1", SELECT_3, BYPASS, WRAP_CNT);
    end
    RST_B = 1'b0;
    BYP_REQ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if ({CNTR_RST_B, SELECT_3, EN_G, BUSY, DONE, BYPASS, WRAP_CNT} !== {5'b01000, 3'd0, 8'd0}) begin
        bad++;
        $display("FAIL midrun_reset i=%0d got=%b/%0d/%0d exp=01000/0/0", i,
                 {CNTR_RST_B, SELECT_3, EN_G, BUSY, DONE}, BYPASS, WRAP_CNT);
      end
    end
    RST_B = 1'b1;
    cyc();
    total++;
    if ({CNTR_RST_B, BUSY} !== 2'b10) begin
      bad++;
      $display("FAIL midrun_release got=%b exp=10", {CNTR_RST_B, BUSY});
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST_B = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    BYP_REQ = 1'b0;
    BYP_VAL = 3'd0;
    CNTR_IN = 3'd0;
    test_reset();
    test_start();
    test_wraps();
    test_bypass();
    test_priority();
    test_timeout();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
